spi_cfg_slave: RTL
==================

Name: spi_cfg_slave

Overview:
- SPI Mode 0 slave that receives configuration frames from the external host and maps them into the stimulator's four 32-bit configuration registers.
- Frame format: 8-bit address byte, then 32 data bits, MSB first.
- Holds conf0, conf1, electrode1 and electrode2, which feed the pulse generator and the H-bridge switch logic.
- Oversamples the SPI pins on the single system clock. Rejects malformed frames and flags them.

Parameters:
- ADDR_W, 8, address field width in bits.
- DATA_W, 32, data field width in bits.
- SYNC_STAGES, 2, synchronizer flops per SPI input (minimum 2).
- CONF1_RST, 32'h0000_0000, reset value of conf1; bit 20 is the enable bit and stays 0 at reset.

Ports:
- clk  in  1  system clock; must be at least 8x the SPI_Clk frequency.
- reset  in  1  asynchronous reset, active high.
- SPI_CS  in  1  chip select, active low, asynchronous to clk.
- SPI_Clk  in  1  SPI clock, Mode 0 (sample on rising edge), asynchronous to clk.
- SPI_MOSI  in  1  master-out slave-in data.
- SPI_MISO  out  1  slave-out data; used only with the optional feature.
- conf0  out  32  register at address 0x00.
- conf1  out  32  register at address 0x01.
- electrode1  out  32  register at address 0x02.
- electrode2  out  32  register at address 0x03.
- wr_valid  out  1  single-cycle pulse when a register is written.
- wr_addr  out  2  index of the register just written; valid while wr_valid is high.
- frame_err  out  1  single-cycle pulse when a frame is rejected.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values:
  - conf0, electrode1, electrode2 = 0.
  - conf1 = CONF1_RST.
  - wr_valid, frame_err, SPI_MISO = 0.
  - Bit counter and shift register cleared; FSM in IDLE.
- Synchronization:
  - SPI_CS, SPI_Clk and SPI_MOSI each pass through SYNC_STAGES flops.
  - Edges are detected against one further registered copy.
  - sck_rise samples the synchronized MOSI, which is delayed by the same amount as the clock, so sampling stays aligned.
- FSM states: IDLE, SHIFT, COMMIT, ERR.
  - IDLE -> SHIFT on synchronized CS falling edge. Clears bit_cnt (6 bits) and the 40-bit shift register.
  - SHIFT: each sck_rise shifts MOSI into the LSB of the shift register; bit_cnt increments and saturates at 41.
  - SHIFT -> COMMIT on CS rising edge when bit_cnt == 40 and addr[7:2] == 0.
  - SHIFT -> ERR on CS rising edge when bit_cnt is 1..39, 41 (overflow), or the address is out of range.
  - SHIFT -> IDLE on CS rising edge when bit_cnt == 0: no write, no error.
  - COMMIT, one cycle:
    - Selected register <= shift[31:0].
    - wr_valid = 1, wr_addr = addr[1:0].
    - Next state IDLE.
  - ERR, one cycle: frame_err = 1, no register changes, next state IDLE.
- Latency: the register update and wr_valid occur exactly 1 clk after the synchronized CS rising edge is detected.
- A new CS falling edge seen during COMMIT or ERR is honoured on the next cycle. The FSM enters SHIFT from IDLE immediately, so back-to-back frames are not lost.
- SPI_Clk edges while CS is high are ignored.
- Reset asserted mid-frame: the frame is aborted with no write and no error pulse. All registers return to their reset values.
- Registers change only in COMMIT, so outputs stay stable during reception.

Optional Feature:
Macro SPI_CFG_READBACK_EN.
- Enabled:
  - addr[7] = 1 denotes a read; addr[6:2] must be 0 and addr[1:0] selects the register.
  - After the 8th sck_rise, the selected register is copied into a 32-bit TX shadow.
  - On each subsequent synchronized SCK falling edge, SPI_MISO presents the next bit, MSB first. Bit 31 is driven after the falling edge that follows address bit 0.
  - A 40-bit read ends in IDLE with no write, no wr_valid and no frame_err. Other bit counts raise frame_err.
  - SPI_MISO returns to 0 when CS is high.
- Disabled:
  - SPI_MISO is tied to 0.
  - Any address with addr[7] = 1 is out of range and raises frame_err.

Test Plan:
- Write 0x00 / 0x32CB2190, then 0x01 / 0x0090C810 -> conf0 = 0x32CB2190 and conf1 = 0x0090C810 (enable bit = 1); two wr_valid pulses with wr_addr 0 then 1.
- Write 0x02 / 0x00008000 and 0x03 / 0x00004000 -> electrode1 = 0x00008000 and electrode2 = 0x00004000; conf0 and conf1 unchanged.
- Truncated frame (address 0x01 plus 24 data bits, then CS high) -> frame_err pulse, conf1 unchanged. Repeat with 41 bits -> frame_err pulse.
- Write to address 0x05 -> frame_err pulse, no register changes. CS low/high with no clocks -> no pulses.
- Assert reset after 20 bits of a write to 0x00 -> conf0 = 0 and no pulses. After release, a full frame writes correctly.
- (SPI_CFG_READBACK_EN) After writing conf0 = 0x32CB2190, read address 0x80 -> MISO shifts 0x32CB2190 MSB-first; no wr_valid, no frame_err.

Source files
------------

// File: rtl/spi_cfg_slave.sv
// spi_cfg_slave: SPI Mode 0 configuration slave.
//
// Receives 40-bit frames on SPI_CS/SPI_Clk/SPI_MOSI, MSB first. Each frame is an
// 8-bit address followed by 32 data bits. A complete frame to addresses 0x00..0x03
// writes one of four configuration registers. The SPI pins are oversampled on clk,
// which must run at least 8x the SPI clock.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   SPI_CS, SPI_Clk         chip select (active low) and SPI clock, asynchronous
//   SPI_MOSI, SPI_MISO      serial data in / out (SPI_MISO is 0 unless readback built)
//   conf0, conf1            registers at 0x00 / 0x01 (conf1 bit 20 = enable)
//   electrode1, electrode2  registers at 0x02 / 0x03
//   wr_valid, wr_addr       one-cycle write strobe and index of the register written
//   frame_err               one-cycle strobe for a rejected frame
//
// Build option: define SPI_CFG_READBACK_EN to allow reads. A read is
// addr = 1_00000_rr; the selected register is then shifted out on SPI_MISO.
module spi_cfg_slave #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] CONF1_RST   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SPI_CS,
  input  logic              SPI_Clk,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [DATA_W-1:0] conf0,
  output logic [DATA_W-1:0] conf1,
  output logic [DATA_W-1:0] electrode1,
  output logic [DATA_W-1:0] electrode2,
  output logic              wr_valid,
  output logic [1:0]        wr_addr,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  // Counter must reach FRAME_W + 1 so an overlong frame is distinguishable.
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CntSat  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit, StErr} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_d_q, sck_d_q;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise;

  // CS chain resets low so a CS held low across reset release never looks like a
  // fresh falling edge; a stale frame is simply ignored until CS goes high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_d_q      <= 1'b0;
      sck_d_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_Clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      cs_d_q      <= cs_s;
      sck_d_q     <= sck_s;
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_fall  = cs_d_q & ~cs_s;
  assign cs_rise  = ~cs_d_q & cs_s;
  // SCK edges only count while the slave is selected.
  assign sck_rise = ~sck_d_q & sck_s & ~cs_s;

  // ---------------------------------------------------------------------------
  // Frame receiver FSM and register file
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [FRAME_W-1:0]  shift_q;
  logic [ADDR_W-1:0]   frame_addr;
  logic                wr_ok, rd_ok;

  assign frame_addr = shift_q[FRAME_W-1 -: ADDR_W];
  assign wr_ok      = (bit_cnt_q == CntFull) && (frame_addr[ADDR_W-1:2] == '0);

`ifdef SPI_CFG_READBACK_EN
  assign rd_ok = (bit_cnt_q == CntFull) && frame_addr[ADDR_W-1] &&
                 (frame_addr[ADDR_W-2:2] == '0);
`else
  assign rd_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      conf0      <= '0;
      conf1      <= CONF1_RST;
      electrode1 <= '0;
      electrode2 <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= 2'd0;
      frame_err  <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StShift;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end
        end
        StShift: begin
          if (cs_rise) begin
            if (bit_cnt_q == '0) begin
              state_q <= StIdle;
            end else if (wr_ok) begin
              state_q <= StCommit;
            end else if (rd_ok) begin
              state_q <= StIdle;
            end else begin
              state_q <= StErr;
            end
          end else if (sck_rise) begin
            shift_q <= {shift_q[FRAME_W-2:0], mosi_s};
            if (bit_cnt_q != CntSat) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        StCommit: begin
          wr_valid <= 1'b1;
          wr_addr  <= frame_addr[1:0];
          unique case (frame_addr[1:0])
            2'd0: conf0      <= shift_q[DATA_W-1:0];
            2'd1: conf1      <= shift_q[DATA_W-1:0];
            2'd2: electrode1 <= shift_q[DATA_W-1:0];
            2'd3: electrode2 <= shift_q[DATA_W-1:0];
          endcase
          // A new frame starting right behind this one must not be dropped.
          if (cs_fall) begin
            state_q   <= StShift;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StErr: begin
          frame_err <= 1'b1;
          if (cs_fall) begin
            state_q   <= StShift;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional readback path
  // ---------------------------------------------------------------------------
`ifdef SPI_CFG_READBACK_EN
  logic              sck_fall;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] tx_q;
  logic              rd_act_q;

  assign sck_fall  = sck_d_q & ~sck_s & ~cs_s;
  // Address as it will look once the bit arriving on this sck_rise is shifted in.
  assign next_addr = {shift_q[ADDR_W-2:0], mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q     <= '0;
      rd_act_q <= 1'b0;
      SPI_MISO <= 1'b0;
    end else if (cs_s || (state_q != StShift)) begin
      rd_act_q <= 1'b0;
      SPI_MISO <= 1'b0;
    end else if (sck_rise && (bit_cnt_q == CNT_W'(ADDR_W - 1))) begin
      rd_act_q <= next_addr[ADDR_W-1] && (next_addr[ADDR_W-2:2] == '0);
      unique case (next_addr[1:0])
        2'd0: tx_q <= conf0;
        2'd1: tx_q <= conf1;
        2'd2: tx_q <= electrode1;
        2'd3: tx_q <= electrode2;
      endcase
    end else if (sck_fall && rd_act_q) begin
      SPI_MISO <= tx_q[DATA_W-1];
      tx_q     <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end
`else
  assign SPI_MISO = 1'b0;
`endif

endmodule
